// File: rtl/core_pkg.sv
// Shared defaults for the core's register file and scoreboard.
package core_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for registers with an outstanding writeback, plus a running busy count.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    flush,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set, inc, dec;

  always_comb begin
    set = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));
    // Counter only moves on real 0->1 / 1->0 transitions; a same-address set and clear nets to zero.
    inc = set && !busy_q[iss_addr];
    dec = wr_en && busy_q[wr_addr] && !(set && (iss_addr == wr_addr));

    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (set)   busy_d[iss_addr] = 1'b1;
      cnt_d = cnt_q + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/gp_register_file_sb.sv
// Parametrised register file with write-to-read bypass and an integrated RAW scoreboard.
module gp_register_file_sb
  import core_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy;
  logic              wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (wr_en && !wr_zero) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] ra;
      logic              hit;
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      hit = wr_en && (wr_addr == ra);
      if ((ZERO_REG != 0) && (ra == ADDR_W'(REG_ZERO))) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
      end
      // A writeback landing this cycle resolves the hazard for its reader.
      rd_busy[i] = busy[ra] && !hit;
    end
  end

endmodule

// File: tb/tb_gp_register_file_sb.sv
// Randomized bench for gp_register_file_sb: default 32-bit/2-port and 64-bit/4-port instances vs a model.
module tb_gp_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, iss_en, flush;
  logic [4:0]  wr_addr, iss_addr;
  logic [63:0] wr_data;
  logic [19:0] rd_addr;

  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [5:0]   cnt_a;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic [5:0]   cnt_b;

  logic [63:0] mreg [32];
  bit          mbusy [32];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gp_register_file_sb dut_a (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr[9:0]),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data[31:0]),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (cnt_a)
  );

  gp_register_file_sb #(
    .DATA_W (64),
    .NUM_RD (4)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return mbusy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic check_all();
    logic [4:0] a;
    for (int i = 0; i < 4; i++) begin
      a = rd_addr[i*5 +: 5];
      check($sformatf("b.rd_data[%0d] r%0d", i, a), rd_data_b[i*64 +: 64], exp_data(a));
      check($sformatf("b.rd_busy[%0d] r%0d", i, a), 64'(rd_busy_b[i]), 64'(exp_busy(a)));
      if (i < 2) begin
        check($sformatf("a.rd_data[%0d] r%0d", i, a), 64'(rd_data_a[i*32 +: 32]),
              64'(exp_data(a) & 64'hFFFF_FFFF));
        check($sformatf("a.rd_busy[%0d] r%0d", i, a), 64'(rd_busy_a[i]), 64'(exp_busy(a)));
      end
    end
    check("a.busy_cnt", 64'(cnt_a), 64'(popcount()));
    check("b.busy_cnt", 64'(cnt_b), 64'(popcount()));
  endtask

  // Apply the clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) mreg[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      end else begin
        if (wr_en) mbusy[wr_addr] = 1'b0;
        if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; iss_en = 0; flush = 0;
    wr_addr = '0; iss_addr = '0; wr_data = '0;
  endtask

  task automatic rd_all(input logic [4:0] a);
    rd_addr = {a, a, a, a};
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0; mbusy[i] = 1'b0;
    end
    idle();
    rd_addr = '0;
    rst = 1;
    @(posedge clk); model_edge(); #1;
    rst = 1; step();
    idle();

    // Reset state on every address.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a + 3), 5'(a + 1), 5'(a)};
      step();
    end

    // Bypass of a write into r5.
    rd_all(5); wr_en = 1; wr_addr = 5; wr_data = 64'hCAFE_F00D_DEAD_BEEF;
    step(); idle(); rd_all(5); step();

    // Writes to r0 are dropped.
    rd_all(0); wr_en = 1; wr_addr = 0; wr_data = 64'h1234;
    step(); idle(); rd_all(0); step(); step();

    // Issue then writeback of r7.
    rd_all(7); iss_en = 1; iss_addr = 7; step();
    idle(); rd_all(7); step();
    wr_en = 1; wr_addr = 7; wr_data = 64'h55; step();
    idle(); rd_all(7); step();

    // Same-cycle clear and re-issue of r3, then flush.
    rd_all(3); iss_en = 1; iss_addr = 3; step();
    wr_en = 1; wr_addr = 3; wr_data = 64'h33; iss_en = 1; iss_addr = 3; step();
    idle(); rd_all(3); step();
    iss_en = 1; iss_addr = 3; step();
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1; iss_addr = 5'(r); step();
    end
    idle(); iss_en = 1; iss_addr = 0; step();
    idle(); flush = 1; iss_en = 1; iss_addr = 6; wr_en = 1; wr_addr = 8; wr_data = 64'h88;
    step();
    idle(); rd_addr = {5'd8, 5'd6, 5'd3, 5'd5}; step();

    // Reset with r9 busy and holding 0xA5.
    wr_en = 1; wr_addr = 9; wr_data = 64'hA5; step();
    idle(); iss_en = 1; iss_addr = 9; rd_all(9); step();
    idle(); rd_all(9); step();
    rst = 1; wr_en = 1; wr_addr = 9; wr_data = 64'hFF; iss_en = 1; iss_addr = 9; step();
    idle(); rd_all(9); step();

    // Random traffic; small-address bias forces collisions between ports.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ad [6];
      for (int k = 0; k < 6; k++)
        ad[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      iss_en   = ($urandom_range(0, 1) == 0);
      wr_addr  = ad[4];
      iss_addr = ad[5];
      wr_data  = {$urandom, $urandom};
      rd_addr  = {ad[3], ad[2], ad[1], ad[0]};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gp_register_file_sb.md
Name: gp_register_file_sb

Overview:
- Parametrised general-purpose register file for the pipelined core, replacing the fixed 32x32, 2-read/1-write file.
- Adds configurable width, depth and read-port count.
- Adds a synchronous reset that clears architectural state, plus write-to-read bypass.
- Adds an integrated scoreboard: tracks registers with an outstanding writeback, so decode can stall on RAW hazards.
- Sits between decode (read + issue) and writeback (write + clear).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never marked busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  per-port flag: the addressed register has an outstanding write.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue of an instruction that will write iss_addr; marks it busy.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  pipeline flush; clears all busy bits, register contents untouched.
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at rising edge):
  - all registers <= 0, all busy bits <= 0, busy_cnt <= 0.
  - rst has priority over wr_en, iss_en and flush in the same cycle.
  - After reset every rd_data reads 0 and every rd_busy reads 0.
- Write:
  - on rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency), per port i:
  - ZERO_REG=1 and rd_addr_i=0 -> rd_data_i = 0.
  - else wr_en=1 and wr_addr=rd_addr_i -> rd_data_i = wr_data (bypass).
  - else rd_data_i = reg[rd_addr_i].
- rd_busy_i = busy[rd_addr_i] AND NOT (wr_en AND wr_addr=rd_addr_i). A same-cycle writeback resolves the hazard.
- Issue takes effect next cycle: an iss_en to register R does not raise rd_busy for R in the same cycle.
- Scoreboard update per rising edge (rst=0), evaluated in this order:
  1. flush=1 -> all busy <= 0; iss_en and the wr_en clear are ignored for the scoreboard. The register write still occurs.
  2. wr_en=1 -> busy[wr_addr] <= 0.
  3. iss_en=1 -> busy[iss_addr] <= 1. Issue wins over a clear of the same address in the same cycle.
- Register 0 (ZERO_REG=1): iss_en to address 0 is ignored; busy[0] is constant 0.
- Re-issue to an already-busy register: the bit stays 1 and busy_cnt is unchanged (one pending writer tracked per register).
- wr_en to a non-busy register is legal; it writes data and leaves the scoreboard unchanged.
- busy_cnt:
  - registered; equals popcount of the busy vector after each update.
  - implemented as an incremental up/down counter (+1 on a 0->1 set, -1 on a 1->0 clear, both -> net 0).
  - forced to 0 on rst or flush.
  - Never exceeds 2**ADDR_W - ZERO_REG.

Decomposition:
- Shared package (core_pkg): DATA_W/ADDR_W defaults, NUM_RD default, the REG_ZERO address constant.
- One sub-module, rf_scoreboard: busy vector, set/clear/flush priority, busy_cnt counter.
- Storage array, bypass muxes and port unpacking stay in gp_register_file_sb.

Test Plan:
- Reset then read all addresses on both ports -> rd_data = 0 and rd_busy = 0 for all; busy_cnt = 0.
- Write 0xDEADBEEF to r5 while port0 reads r5 in the same cycle -> port0 shows 0xDEADBEEF that cycle (bypass) and after.
- Write 0x1234 to r0 with ZERO_REG=1 -> r0 reads 0 in the same cycle and every later cycle.
- Issue r7, next cycle read r7 -> rd_busy=1 and busy_cnt=1. Then wr_en r7 with 0x55 -> same cycle rd_busy=0 and rd_data=0x55; next cycle busy_cnt=0.
- Same cycle wr_en r3 (busy) and iss_en r3 -> r3 remains busy and busy_cnt unchanged. Issue r1, r2, r4, then flush -> busy_cnt=0, register contents preserved.
- Assert rst mid-sequence with r9 busy holding 0xA5 -> next cycle r9 reads 0, not busy, busy_cnt=0. Repeat with NUM_RD=4, DATA_W=64 to confirm parametrisation.
